reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/reset_seq_if.sv | 25 ++
 rtl/reset_seq_timer.sv | 36 +++
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_WAIT_ACK,
    S_GAP,
    S_RUN
  } seqState_e;

  function automatic int cntWidth(int minAssert, int gap, int timeout);
    int m;
    m = minAssert;
    if (gap > m) m = gap;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

  function automatic bit paramsLegal(int nStages, int minAssert, int gap, int timeout);
    return (nStages >= 1) && (nStages <= 16) && (minAssert >= 1) &&
           (gap >= 0) && (timeout >= 1);
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Request/acknowledge and status bundle between the reset tree and the sequencer.
interface reset_seq_if #(
  parameter int NSTAGES = 4
);

  logic               rstReq;
  logic               swReq;
  logic [NSTAGES-1:0] stageAck;
  logic [NSTAGES-1:0] stageRst;
  logic               busy;
  logic               done;
  logic               timeoutErr;
  logic [3:0]         errStage;

  modport master (
    output rstReq, swReq, stageAck,
    input  stageRst, busy, done, timeoutErr, errStage
  );

  modport slave (
    input  rstReq, swReq, stageAck,
    output stageRst, busy, done, timeoutErr, errStage
  );

endinterface

// File: rtl/reset_seq_timer.sv
// Loadable up-counter with terminal-count compare, shared by every timed phase.
module reset_seq_timer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] countQ;
  logic [WIDTH-1:0] countD;

  // Saturate instead of wrapping so a stalled phase can never alias a short count.
  always_comb begin
    countD = countQ;
    if (clr_i) begin
      countD = '0;
    end else if (inc_i && (countQ != '1)) begin
      countD = countQ + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countQ <= '0;
    end else begin
      countQ <= countD;
    end
  end

  assign hit_o = (countQ == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release controller: all stage resets assert together and release
// one at a time, each gated on its acknowledge with a timeout fallback.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NSTAGES    = 4,
  parameter int MIN_ASSERT = 16,
  parameter int GAP        = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  reset_seq_if.slave bus_io
);

  localparam int            CW     = cntWidth(MIN_ASSERT, GAP, TIMEOUT);
  localparam logic [CW-1:0] MA_TC  = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] TO_TC  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_TC = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [3:0]    LAST   = 4'(NSTAGES - 1);

  if (!paramsLegal(NSTAGES, MIN_ASSERT, GAP, TIMEOUT)) begin : gIllegalParams
    $error("reset_sequencer: illegal parameter set");
  end

  seqState_e          stateQ;
  logic [3:0]         kQ;
  logic [NSTAGES-1:0] stageRstQ;
  logic               busyQ;
  logic               doneQ;
  logic               errQ;
  logic [3:0]         errStageQ;

  logic               req;
  logic               ackSel;
  logic               timerClr;
  logic               timerInc;
  logic [CW-1:0]      timerTerm;
  logic               timerHit;

  assign req = bus_io.rstReq | bus_io.swReq;

  function automatic logic [NSTAGES-1:0] releaseStage(logic [NSTAGES-1:0] v, logic [3:0] idx);
    logic [NSTAGES-1:0] r;
    r = v;
    for (int i = 0; i < NSTAGES; i++) begin
      if (idx == 4'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    ackSel = 1'b0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (kQ == 4'(i)) ackSel = bus_io.stageAck[i];
    end
  end

  // The one timer is reloaded on every phase change; a request always restarts it.
  always_comb begin
    timerClr  = 1'b0;
    timerInc  = 1'b0;
    timerTerm = MA_TC;
    unique case (stateQ)
      S_ASSERT: begin
        timerTerm = MA_TC;
        timerClr  = timerHit;
        timerInc  = !timerHit;
      end
      S_WAIT_ACK: begin
        timerTerm = TO_TC;
        timerClr  = ackSel | timerHit;
        timerInc  = !(ackSel | timerHit);
      end
      S_GAP: begin
        timerTerm = GAP_TC;
        timerClr  = timerHit;
        timerInc  = !timerHit;
      end
      default: begin
        timerClr = 1'b1;
      end
    endcase
    if (req) begin
      timerClr = 1'b1;
      timerInc = 1'b0;
    end
  end

  reset_seq_timer #(
    .WIDTH(CW)
  ) uTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timerClr),
    .inc_i (timerInc),
    .term_i(timerTerm),
    .hit_o (timerHit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= S_ASSERT;
      kQ        <= 4'd0;
      stageRstQ <= '1;
      busyQ     <= 1'b1;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      errStageQ <= 4'd0;
    end else if (req) begin
      stateQ    <= S_ASSERT;
      kQ        <= 4'd0;
      stageRstQ <= '1;
      busyQ     <= 1'b1;
      doneQ     <= 1'b0;
    end else begin
      unique case (stateQ)
        S_ASSERT: begin
          if (timerHit) begin
            stageRstQ <= releaseStage(stageRstQ, 4'd0);
            busyQ     <= |releaseStage(stageRstQ, 4'd0);
            kQ        <= 4'd0;
            stateQ    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // A timeout is logged, then treated exactly like an acknowledge.
          if (ackSel || timerHit) begin
            if (!ackSel) begin
              errQ      <= 1'b1;
              errStageQ <= kQ;
            end
            if (kQ == LAST) begin
              stateQ <= S_RUN;
              doneQ  <= 1'b1;
            end else if (GAP == 0) begin
              stageRstQ <= releaseStage(stageRstQ, kQ + 4'd1);
              busyQ     <= |releaseStage(stageRstQ, kQ + 4'd1);
              kQ        <= kQ + 4'd1;
            end else begin
              stateQ <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (timerHit) begin
            stageRstQ <= releaseStage(stageRstQ, kQ + 4'd1);
            busyQ     <= |releaseStage(stageRstQ, kQ + 4'd1);
            kQ        <= kQ + 4'd1;
            stateQ    <= S_WAIT_ACK;
          end
        end
        S_RUN: begin
        end
        default: begin
          stateQ <= S_ASSERT;
        end
      endcase
    end
  end

  assign bus_io.stageRst   = stageRstQ;
  assign bus_io.busy       = busyQ;
  assign bus_io.done       = doneQ;
  assign bus_io.timeoutErr = errQ;
  assign bus_io.errStage   = errStageQ;

endmodule

// File: tb/tb_reset_sequencer.sv
// Drives a default 4-stage sequencer and a 2-stage GAP=0 variant from one stimulus
// stream and compares both against a count-based model of the release schedule.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rstReq = 1'b0;
  logic       swReq = 1'b0;
  logic [3:0] ack = 4'hF;

  int checks = 0;
  int errors = 0;
  int edgeNo = 0;

  // Model: per DUT, how many stages are released and how many have been acknowledged.
  int nS[2]   = '{4, 2};
  int minA[2] = '{16, 3};
  int gapP[2] = '{8, 0};
  int toP[2]  = '{256, 6};
  int released[2];
  int acked[2];
  int cnt[2];
  int errM[2];
  int errStageM[2];

  always #5 clk = ~clk;

  reset_seq_if #(.NSTAGES(4)) ifA ();
  reset_seq_if #(.NSTAGES(2)) ifB ();

  assign ifA.rstReq   = rstReq;
  assign ifA.swReq    = swReq;
  assign ifA.stageAck = ack;
  assign ifB.rstReq   = rstReq;
  assign ifB.swReq    = swReq;
  assign ifB.stageAck = ack[1:0];

  reset_sequencer #(
    .NSTAGES(4), .MIN_ASSERT(16), .GAP(8), .TIMEOUT(256)
  ) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(ifA.slave)
  );

  reset_sequencer #(
    .NSTAGES(2), .MIN_ASSERT(3), .GAP(0), .TIMEOUT(6)
  ) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(ifB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (edge %0d)", tag, obs, exp, edgeNo);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      released[d]  = 0;
      acked[d]     = 0;
      cnt[d]       = 0;
      errM[d]      = 0;
      errStageM[d] = 0;
    end
  endtask

  task automatic modelStep(input logic rq, input logic sw, input logic [3:0] a);
    for (int d = 0; d < 2; d++) begin
      if (rq || sw) begin
        released[d] = 0;
        acked[d]    = 0;
        cnt[d]      = 0;
      end else if (released[d] == 0) begin
        if (cnt[d] == minA[d] - 1) begin
          released[d] = 1;
          cnt[d]      = 0;
        end else begin
          cnt[d]++;
        end
      end else if (acked[d] < released[d]) begin
        int k;
        k = released[d] - 1;
        if (a[k] || (cnt[d] == toP[d] - 1)) begin
          if (!a[k]) begin
            errM[d]      = 1;
            errStageM[d] = k;
          end
          acked[d]++;
          cnt[d] = 0;
          if ((gapP[d] == 0) && (acked[d] < nS[d])) released[d]++;
        end else begin
          cnt[d]++;
        end
      end else if (acked[d] < nS[d]) begin
        if (cnt[d] == gapP[d] - 1) begin
          released[d]++;
          cnt[d] = 0;
        end else begin
          cnt[d]++;
        end
      end
    end
  endtask

  function automatic logic [31:0] expRst(int d);
    logic [31:0] m;
    m = '0;
    for (int i = released[d]; i < nS[d]; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic compareAll();
    checkOutput("A.stageRst", 32'(ifA.stageRst), expRst(0));
    checkOutput("A.busy", 32'(ifA.busy), 32'(released[0] < nS[0]));
    checkOutput("A.done", 32'(ifA.done), 32'(acked[0] == nS[0]));
    checkOutput("A.timeoutErr", 32'(ifA.timeoutErr), 32'(errM[0]));
    checkOutput("A.errStage", 32'(ifA.errStage), 32'(errStageM[0]));
    checkOutput("B.stageRst", 32'(ifB.stageRst), expRst(1));
    checkOutput("B.busy", 32'(ifB.busy), 32'(released[1] < nS[1]));
    checkOutput("B.done", 32'(ifB.done), 32'(acked[1] == nS[1]));
    checkOutput("B.timeoutErr", 32'(ifB.timeoutErr), 32'(errM[1]));
    checkOutput("B.errStage", 32'(ifB.errStage), 32'(errStageM[1]));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next fall.
  task automatic applyStimulus(input logic rq, input logic sw, input logic [3:0] a);
    rstReq = rq;
    swReq  = sw;
    ack    = a;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(rq, sw, a);
    @(negedge clk);
    edgeNo++;
    compareAll();
  endtask

  task automatic waitForA(input logic [3:0] target, input logic [3:0] a, input int limit);
    int n;
    n = 0;
    while ((ifA.stageRst !== target) && (n < limit)) begin
      applyStimulus(1'b0, 1'b0, a);
      n++;
    end
    checkOutput("A.waitRelease", 32'(ifA.stageRst), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at edge %0d", edgeNo);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r1;
    int r2;
    logic [3:0] holdMask;

    modelReset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compareAll();
    checkOutput("rstVal.stageRst", 32'(ifA.stageRst), 32'hF);
    checkOutput("rstVal.busy", 32'(ifA.busy), 32'h1);

    $display("[TB] default schedule, acks tied high");
    rst_n = 1'b1;
    for (int e = 0; e < 50; e++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      if (e == 14) checkOutput("A.hold14", 32'(ifA.stageRst), 32'hF);
      if (e == 15) checkOutput("A.rel15", 32'(ifA.stageRst), 32'hE);
      if (e == 24) checkOutput("A.rel24", 32'(ifA.stageRst), 32'hC);
      if (e == 33) checkOutput("A.rel33", 32'(ifA.stageRst), 32'h8);
      if (e == 42) checkOutput("A.rel42", 32'(ifA.stageRst), 32'h0);
      if (e == 42) checkOutput("A.notDone42", 32'(ifA.done), 32'h0);
      if (e == 43) checkOutput("A.done43", 32'(ifA.done), 32'h1);
      if (e == 2) checkOutput("B.rel2", 32'(ifB.stageRst), 32'h2);
      if (e == 3) checkOutput("B.rel3", 32'(ifB.stageRst), 32'h0);
      if (e == 4) checkOutput("B.done4", 32'(ifB.done), 32'h1);
    end

    $display("[TB] RST_REQ held for 40 cycles");
    repeat (40) applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("A.reqHold", 32'(ifA.stageRst), 32'hF);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      if (i == 14) checkOutput("A.afterReq14", 32'(ifA.stageRst), 32'hF);
      if (i == 15) checkOutput("A.afterReq15", 32'(ifA.stageRst), 32'hE);
    end

    $display("[TB] stage 1 acknowledge missing");
    applyStimulus(1'b0, 1'b1, 4'b1101);
    waitForA(4'b1100, 4'b1101, 100);
    r1 = edgeNo;
    waitForA(4'b1000, 4'b1101, 600);
    r2 = edgeNo;
    checkOutput("A.timeoutSpacing", 32'(r2 - r1), 32'd264);
    for (int i = 0; (i < 100) && !ifA.done; i++) applyStimulus(1'b0, 1'b0, 4'b1101);
    checkOutput("A.doneAfterTo", 32'(ifA.done), 32'h1);
    checkOutput("A.errSticky", 32'(ifA.timeoutErr), 32'h1);
    checkOutput("A.errStage1", 32'(ifA.errStage), 32'h1);

    $display("[TB] SW_REQ during gap before stage 3");
    applyStimulus(1'b0, 1'b1, 4'hF);
    waitForA(4'b1000, 4'hF, 100);
    applyStimulus(1'b0, 1'b0, 4'hF);
    applyStimulus(1'b0, 1'b0, 4'hF);
    applyStimulus(1'b0, 1'b1, 4'hF);
    checkOutput("A.swInGap", 32'(ifA.stageRst), 32'hF);
    checkOutput("A.errKept", 32'(ifA.timeoutErr), 32'h1);
    repeat (50) applyStimulus(1'b0, 1'b0, 4'hF);
    checkOutput("A.resequenced", 32'(ifA.done), 32'h1);

    $display("[TB] asynchronous reset, then SW_REQ on the timeout edge");
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("A.asyncRst", 32'(ifA.stageRst), 32'hF);
    checkOutput("A.asyncErr", 32'(ifA.timeoutErr), 32'h0);
    checkOutput("A.asyncDone", 32'(ifA.done), 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 4'b1101);
    rst_n = 1'b1;
    waitForA(4'b1100, 4'b1101, 100);
    repeat (255) applyStimulus(1'b0, 1'b0, 4'b1101);
    applyStimulus(1'b0, 1'b1, 4'b1101);
    checkOutput("A.swOnTimeout", 32'(ifA.stageRst), 32'hF);
    checkOutput("A.swOnTimeoutErr", 32'(ifA.timeoutErr), 32'h0);
    checkOutput("A.swOnTimeoutStage", 32'(ifA.errStage), 32'h0);

    $display("[TB] randomized requests, acknowledges and resets");
    for (int blk = 0; blk < 8; blk++) begin
      holdMask = 4'($urandom_range(0, 15)) | ((blk % 2 == 0) ? 4'hF : 4'h0);
      for (int i = 0; i < 400; i++) begin
        rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
        applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0),
                      4'($urandom_range(0, 15)) & holdMask);
      end
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
